addsub_serial: RTL and testbench
================================

ADDSUB_SERIAL -- requirements
Module: addsub_serial

Interface
REQ-001 Parameter WIDTH, 16, operand/result width in bits; SHALL be a multiple of DIGIT, minimum 4.
REQ-002 Parameter DIGIT, 4, bits processed per clock; N = WIDTH/DIGIT cycles per operation.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  operand request.
REQ-006 in_ready  output  1  block can accept operands.
REQ-007 a  input  WIDTH  first operand, two's complement.
REQ-008 b  input  WIDTH  second operand, two's complement.
REQ-009 sub  input  1  0: a+b, 1: a-b.
REQ-010 out_valid  output  1  result available.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 result  output  WIDTH  sum/difference.
REQ-013 carry  output  1  carry out of MSB (for subtract, 1 = no borrow).
REQ-014 overflow  output  1  signed overflow.
REQ-015 zero  output  1  result == 0.

Function
REQ-016 FSM states IDLE, RUN, DONE SHALL be used; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-017 IDLE: on in_valid & in_ready, a, b^{WIDTH{sub}}, carry-in = sub and the sign of a SHALL be registered, digit counter cleared, state -> RUN.
REQ-018 RUN: each cycle one DIGIT-bit slice, LSB slice first, SHALL be added with the registered carry; carry register updated with the slice carry-out.
REQ-019 After the Nth RUN cycle state SHALL go to DONE; out_valid SHALL be high exactly N cycles after the accepting edge.
REQ-020 carry SHALL equal the carry out of bit WIDTH-1; overflow SHALL equal carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
REQ-021 DONE: result, carry, overflow, zero SHALL be held stable until out_valid & out_ready, then state -> IDLE on that edge.
REQ-022 No accept SHALL occur in the handoff cycle; the next accept is earliest one cycle after the result is consumed.
REQ-023 in_valid, a, b, sub SHALL be ignored in RUN and DONE; operand changes after acceptance SHALL NOT affect the result.
REQ-024 Outside DONE, result/carry/overflow/zero SHALL retain their last values (zero after reset).
REQ-025 Counter wrap: the digit counter SHALL count 0..N-1 and SHALL NOT exceed N-1.

Reset
REQ-026 rst_n low SHALL immediately force state IDLE, counter 0, in_ready 1, out_valid 0, result 0, carry 0, overflow 0, zero 0.
REQ-027 Reset asserted mid-RUN or in DONE SHALL abort the operation with no output pulse; the first accept after release SHALL compute correctly.

Configuration
REQ-028 Macro ADDSUB_SATURATE_EN: when defined, on overflow result SHALL be 0 followed by ones (signed max) if the registered sign of a is 0, else 1 followed by zeros (signed min); overflow and carry still reported unchanged.
REQ-029 Without ADDSUB_SATURATE_EN, result SHALL be the wrapped WIDTH-bit value and no saturation logic SHALL be present.

Verification (WIDTH=16, DIGIT=4, N=4)
REQ-030 a=0x7FFF, b=0x0001, sub=0 -> out_valid 4 cycles after accept, result 0x8000 (0x7FFF with SATURATE_EN), carry 0, overflow 1.
REQ-031 a=0x0005, b=0x0005, sub=1 -> result 0x0000, zero 1, carry 1, overflow 0.
REQ-032 a=0xFFFF, b=0x0001, sub=0 -> result 0x0000, carry 1, overflow 0, zero 1.
REQ-033 a=0x8000, b=0x0001, sub=1 -> result 0x7FFF (0x8000 with SATURATE_EN), carry 1, overflow 1.
REQ-034 out_ready held 0 for 10 cycles in DONE with in_valid toggling and a/b changing -> outputs stable, in_ready 0, no new accept; release -> IDLE next cycle.
REQ-035 rst_n pulsed low during 2nd RUN cycle -> all outputs 0 asynchronously, no out_valid; after release a=0x1234, b=0x0101 add -> 0x1335.

Source files
------------

// File: rtl/addsub_serial_if.sv
// addsub_serial_if: operand/result handshake bundle for addsub_serial.
//   master: drives in_valid, a, b, sub, out_ready; observes in_ready and the result group.
//   slave : the adder side; drives in_ready, out_valid, result, carry, overflow, zero.
// Signals:
//   in_valid/in_ready   operand handshake
//   a, b                WIDTH-bit two's complement operands
//   sub                 0: a+b, 1: a-b
//   out_valid/out_ready result handshake
//   result              WIDTH-bit sum/difference
//   carry               carry out of the MSB (subtract: 1 = no borrow)
//   overflow            signed overflow
//   zero                result == 0
interface addsub_serial_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             overflow;
  logic             zero;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, result, carry, overflow, zero
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, result, carry, overflow, zero
  );
endinterface

// File: rtl/addsub_serial.sv
// addsub_serial: digit-serial two's complement adder/subtractor.
// Processes DIGIT bits per clock, LSB slice first, so one operation takes N = WIDTH/DIGIT
// RUN cycles; out_valid rises exactly N cycles after the accepting edge.
// Ports:
//   clk    single clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    addsub_serial_if.slave (operand and result handshakes, see interface header)
// Parameters:
//   WIDTH  operand/result width (multiple of DIGIT, >= 4)
//   DIGIT  bits processed per clock
// Build option:
//   ADDSUB_SATURATE_EN  when defined, an overflowing result is clamped to signed max/min
//                       chosen by the sign of a; carry and overflow are still reported raw.
module addsub_serial #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  addsub_serial_if.slave bus
);

  localparam int unsigned N    = WIDTH / DIGIT;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
  // Partial-result store holds the N-1 slices produced before the final one.
  localparam int unsigned AccW = (N > 1) ? (WIDTH - DIGIT) : 1;

  if ((WIDTH % DIGIT) != 0 || WIDTH < 4 || DIGIT == 0) begin : g_param_check
    $error("addsub_serial: WIDTH must be a multiple of DIGIT and at least 4");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e state_q, state_d;

  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;   // already inverted for subtract
  logic             c_q, c_d;   // running carry between slices
  logic [AccW-1:0]  acc_q, acc_d;

  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             overflow_q, overflow_d;
  logic             zero_q, zero_d;

`ifdef ADDSUB_SATURATE_EN
  logic             sign_q, sign_d;  // sign of a, picks the clamp direction
`endif

  logic             accept;
  logic             last_slice;
  logic [DIGIT-1:0] a_sl, b_sl;
  logic [DIGIT:0]   sl_sum;
  logic             msb_cin;
  logic             ovf_now;
  logic [WIDTH-1:0] wrapped;
  logic [AccW-1:0]  acc_shift;
  logic [WIDTH-1:0] final_res;

  assign accept     = (state_q == StIdle) && bus.in_valid;
  assign last_slice = (cnt_q == CntW'(N - 1));

  // One slice of the ripple add, fed by the carry left over from the previous slice.
  assign a_sl    = a_q[DIGIT-1:0];
  assign b_sl    = b_q[DIGIT-1:0];
  assign sl_sum  = {1'b0, a_sl} + {1'b0, b_sl} + {{DIGIT{1'b0}}, c_q};
  // Carry into the top bit of the slice; on the last slice this is the carry into bit WIDTH-1.
  assign msb_cin = sl_sum[DIGIT-1] ^ a_sl[DIGIT-1] ^ b_sl[DIGIT-1];
  assign ovf_now = msb_cin ^ sl_sum[DIGIT];

  if (N > 1) begin : g_multi
    logic [WIDTH-1:0] joined;
    assign joined    = {sl_sum[DIGIT-1:0], acc_q};
    assign wrapped   = joined;
    // New slice enters at the top; older slices drift toward bit 0.
    assign acc_shift = AccW'(joined >> DIGIT);
  end else begin : g_single
    assign wrapped   = sl_sum[DIGIT-1:0];
    assign acc_shift = '0;
  end

`ifdef ADDSUB_SATURATE_EN
  always_comb begin
    final_res = wrapped;
    if (ovf_now) begin
      final_res = sign_q ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end
`else
  assign final_res = wrapped;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (bus.in_valid) state_d = StRun;
      StRun:   if (last_slice) state_d = StDone;
      StDone:  if (bus.out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs.
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state_q)
      StIdle:  bus.in_ready = 1'b1;
      StDone:  bus.out_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath next state.
  always_comb begin
    cnt_d      = cnt_q;
    a_d        = a_q;
    b_d        = b_q;
    c_d        = c_q;
    acc_d      = acc_q;
    result_d   = result_q;
    carry_d    = carry_q;
    overflow_d = overflow_q;
    zero_d     = zero_q;
`ifdef ADDSUB_SATURATE_EN
    sign_d     = sign_q;
`endif
    case (state_q)
      StIdle: begin
        if (accept) begin
          a_d   = bus.a;
          b_d   = bus.b ^ {WIDTH{bus.sub}};
          c_d   = bus.sub;  // +1 completes the two's complement of b
          cnt_d = '0;
`ifdef ADDSUB_SATURATE_EN
          sign_d = bus.a[WIDTH-1];
`endif
        end
      end
      StRun: begin
        a_d   = a_q >> DIGIT;
        b_d   = b_q >> DIGIT;
        c_d   = sl_sum[DIGIT];
        acc_d = acc_shift;
        if (last_slice) begin
          // Clearing here keeps the counter inside 0..N-1.
          cnt_d      = '0;
          result_d   = final_res;
          carry_d    = sl_sum[DIGIT];
          overflow_d = ovf_now;
          zero_d     = (final_res == '0);
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= 1'b0;
      acc_q      <= '0;
      result_q   <= '0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
`ifdef ADDSUB_SATURATE_EN
      sign_q     <= 1'b0;
`endif
    end else begin
      cnt_q      <= cnt_d;
      a_q        <= a_d;
      b_q        <= b_d;
      c_q        <= c_d;
      acc_q      <= acc_d;
      result_q   <= result_d;
      carry_q    <= carry_d;
      overflow_q <= overflow_d;
      zero_q     <= zero_d;
`ifdef ADDSUB_SATURATE_EN
      sign_q     <= sign_d;
`endif
    end
  end

  assign bus.result   = result_q;
  assign bus.carry    = carry_q;
  assign bus.overflow = overflow_q;
  assign bus.zero     = zero_q;

endmodule

// File: tb/tb_addsub_serial.sv
// Testbench for addsub_serial: scoreboard of expected results pushed at accept and
// popped when out_valid appears; one task per scenario.
module tb_addsub_serial;

  localparam int unsigned W = 16;
  localparam int unsigned D = 4;
  localparam int unsigned N = W / D;

  typedef struct packed {
    logic [W-1:0] res;
    logic         carry;
    logic         ovf;
    logic         zero;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  addsub_serial_if #(.WIDTH(W)) bus ();

  addsub_serial #(.WIDTH(W), .DIGIT(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int acc_cyc = 0;
  exp_t sb[$];

  always @(posedge clk) cyc++;

  // Reference: wide-arithmetic add, carry into the MSB taken from the low W-1 bits.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    exp_t e;
    logic [W-1:0] bx;
    logic [W:0]   full;
    logic [W-1:0] low;
    bx      = b ^ {W{s}};
    full    = {1'b0, a} + {1'b0, bx} + {{W{1'b0}}, s};
    low     = {1'b0, a[W-2:0]} + {1'b0, bx[W-2:0]} + {{(W-1){1'b0}}, s};
    e.carry = full[W];
    e.ovf   = full[W] ^ low[W-1];
    e.res   = full[W-1:0];
`ifdef ADDSUB_SATURATE_EN
    if (e.ovf) e.res = a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
    e.zero  = (e.res == '0);
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands, wait for the accepting edge, then scramble the inputs.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          output bit ok);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.a = a;
    bus.b = b;
    bus.sub = s;
    while (!bus.in_ready && n < 50) begin
      tick();
      n++;
    end
    tests++;
    if (!bus.in_ready) begin
      fails++;
      $display("FAIL accept_wait: in_ready=%b, required 1", bus.in_ready);
      bus.in_valid = 1'b0;
      ok = 1'b0;
      return;
    end
    sb.push_back(model(a, b, s));
    tick();
    acc_cyc = cyc;
    bus.in_valid = 1'b0;
    bus.a = W'($urandom);
    bus.b = W'($urandom);
    bus.sub = 1'($urandom);
    tests++;
    if (bus.in_ready !== 1'b0) begin
      fails++;
      $display("FAIL in_ready_after_accept: got %b, required 0", bus.in_ready);
    end
    ok = 1'b1;
  endtask

  // Wait for the result with out_ready high, check latency and values, then the handoff.
  task automatic finish_op(input string name);
    int   lat;
    exp_t e;
    lat = 0;
    bus.out_ready = 1'b1;
    while (!bus.out_valid && lat < 50) begin
      tick();
      lat++;
    end
    tests++;
    if (!bus.out_valid) begin
      fails++;
      $display("FAIL %s timeout: out_valid=%b, required 1", name, bus.out_valid);
      void'(sb.pop_front());
      return;
    end
    if (lat != N) begin
      fails++;
      $display("FAIL %s latency: got %0d cycles, required %0d", name, lat, N);
    end
    e = sb.pop_front();
    tests++;
    if (bus.result !== e.res) begin
      fails++;
      $display("FAIL %s result: got %h, required %h", name, bus.result, e.res);
    end
    tests++;
    if ({bus.carry, bus.overflow, bus.zero} !== {e.carry, e.ovf, e.zero}) begin
      fails++;
      $display("FAIL %s flags c/v/z: got %b%b%b, required %b%b%b", name,
               bus.carry, bus.overflow, bus.zero, e.carry, e.ovf, e.zero);
    end
    tests++;
    if (bus.in_ready !== 1'b0) begin
      fails++;
      $display("FAIL %s in_ready_in_done: got %b, required 0", name, bus.in_ready);
    end
    tick();
    tests++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      fails++;
      $display("FAIL %s handoff: out_valid/in_ready got %b%b, required 01", name,
               bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s);
    bit ok;
    start_op(a, b, s, ok);
    if (ok) finish_op(name);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    tests++;
    if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
      fails++;
      $display("FAIL reset_hs: in_ready/out_valid got %b%b, required 10",
               bus.in_ready, bus.out_valid);
    end
    tests++;
    if ({bus.result, bus.carry, bus.overflow, bus.zero} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: result=%h c=%b v=%b z=%b, required all 0",
               bus.result, bus.carry, bus.overflow, bus.zero);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_vectors();
    run_op("add_ovf", 16'h7FFF, 16'h0001, 1'b0);
    run_op("sub_zero", 16'h0005, 16'h0005, 1'b1);
    run_op("add_wrap", 16'hFFFF, 16'h0001, 1'b0);
    run_op("sub_ovf", 16'h8000, 16'h0001, 1'b1);
    run_op("sub_borrow", 16'h0003, 16'h0007, 1'b1);
    run_op("add_neg_ovf", 16'h8000, 16'hFFFF, 1'b0);
  endtask

  task automatic test_stall();
    bit   ok;
    int   n;
    exp_t e;
    bus.out_ready = 1'b0;
    start_op(16'h1234, 16'h4321, 1'b1, ok);
    if (!ok) return;
    e = sb[0];
    n = 0;
    while (!bus.out_valid && n < 50) begin
      tick();
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = ~bus.in_valid;
      bus.a = W'($urandom);
      bus.b = W'($urandom);
      bus.sub = 1'($urandom);
      tick();
      tests++;
      if ({bus.out_valid, bus.in_ready} !== 2'b10 || bus.result !== e.res ||
          {bus.carry, bus.overflow, bus.zero} !== {e.carry, e.ovf, e.zero}) begin
        fails++;
        $display("FAIL stall_hold[%0d]: ov/ir=%b%b res=%h cvz=%b%b%b, required 10 %h %b%b%b",
                 i, bus.out_valid, bus.in_ready, bus.result, bus.carry, bus.overflow,
                 bus.zero, e.res, e.carry, e.ovf, e.zero);
      end
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    void'(sb.pop_front());
    tests++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      fails++;
      $display("FAIL stall_release: ov/ir got %b%b, required 01", bus.out_valid, bus.in_ready);
    end
    tick();
    tests++;
    if (bus.result !== e.res || bus.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL idle_retain: result=%h in_ready=%b, required %h 1",
               bus.result, bus.in_ready, e.res);
    end
  endtask

  task automatic test_reset_mid_run();
    bit ok;
    bus.out_ready = 1'b1;
    start_op(16'h1111, 16'h2222, 1'b0, ok);
    if (!ok) return;
    void'(sb.pop_back());
    tick();  // now in the second RUN cycle
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({bus.in_ready, bus.out_valid} !== 2'b10 ||
        {bus.result, bus.carry, bus.overflow, bus.zero} !== '0) begin
      fails++;
      $display("FAIL async_reset: ir/ov=%b%b res=%h cvz=%b%b%b, required 10 0000 000",
               bus.in_ready, bus.out_valid, bus.result, bus.carry, bus.overflow, bus.zero);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      tests++;
      if (bus.out_valid !== 1'b0) begin
        fails++;
        $display("FAIL reset_no_pulse[%0d]: out_valid=%b, required 0", i, bus.out_valid);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run_op("post_reset", 16'h1234, 16'h0101, 1'b0);
    tests++;
    if (bus.result !== 16'h1335) begin
      fails++;
      $display("FAIL post_reset_const: result=%h, required 1335", bus.result);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int prev;
    bus.out_ready = 1'b1;
    prev = -1;
    for (int i = 0; i < 12; i++) begin
      start_op(W'($urandom), W'($urandom), 1'($urandom), ok);
      if (!ok) return;
      if (prev >= 0) begin
        tests++;
        if (acc_cyc - prev != int'(N) + 2) begin
          fails++;
          $display("FAIL b2b_period[%0d]: got %0d cycles, required %0d", i, acc_cyc - prev,
                   N + 2);
        end
      end
      prev = acc_cyc;
      finish_op("b2b");
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.sub = 1'b0;
    test_reset();
    test_vectors();
    test_stall();
    test_reset_mid_run();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
